// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants, state encoding and row helpers for the text writer and displayer
//
// Purpose: screen geometry, the ASCII codes the writer reacts to, the FSM
// state encoding, and small helpers shared by the writer and the displayer.
// Ports: none (package).
package text_pkg;

  localparam int COLS = 70;
  localparam int ROWS = 30;

  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_BS     = 8'h08;
  localparam logic [7:0] ASCII_PROMPT = 8'h3E;
  localparam logic [7:0] ASCII_BLANK  = 8'h00;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2
  } text_state_e;

  // Logical screen row -> physical RAM row. Both inputs are below rows, so
  // one conditional subtract replaces the modulo.
  function automatic logic [4:0] phys_row(input logic [4:0] top,
                                          input logic [4:0] lrow,
                                          input logic [4:0] rows);
    logic [5:0] sum;
    sum = {1'b0, top} + {1'b0, lrow};
    if (sum >= {1'b0, rows}) begin
      sum = sum - {1'b0, rows};
    end
    return sum[4:0];
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_writer_if.sv
// rtl/text_writer_if.sv - keyboard input handshake, video RAM write port and cursor/scroll status
//
// Purpose: bundles the character input handshake, the video RAM write port
// and the exported cursor/scroll state of the text writer.
// Signals:
//   in_valid/in_ascii/in_ready : ASCII code handshake (accepted on valid && ready)
//   vwraddr_h/vwraddr_v/vwrdata/vwren : video RAM write port, one cell per cycle
//   top_row/cur_x/cur_y        : scroll base and logical cursor for the displayer
// Modports: slave = the text writer, master = the environment driving it.
interface text_writer_if;

  logic       in_valid;
  logic [7:0] in_ascii;
  logic       in_ready;
  logic [6:0] vwraddr_h;
  logic [4:0] vwraddr_v;
  logic [7:0] vwrdata;
  logic       vwren;
  logic [4:0] top_row;
  logic [6:0] cur_x;
  logic [4:0] cur_y;

  modport slave (
    input  in_valid, in_ascii,
    output in_ready, vwraddr_h, vwraddr_v, vwrdata, vwren, top_row, cur_x, cur_y
  );

  modport master (
    output in_valid, in_ascii,
    input  in_ready, vwraddr_h, vwraddr_v, vwrdata, vwren, top_row, cur_x, cur_y
  );

endinterface

// File: rtl/text_writer.sv
// rtl/text_writer.sv - terminal-style character writer feeding the video RAM write port
//
// Purpose: accepts ASCII codes, keeps the cursor, writes characters into the
// COLS x ROWS video RAM and scrolls by advancing a circular top_row base
// (the RAM is never read or copied).
// Ports:
//   clk : pixel-domain clock, rising edge
//   rst : synchronous active-high reset
//   bus : text_writer_if.slave (input handshake, RAM write port, cursor/scroll)
module text_writer #(
  parameter int COLS = text_pkg::COLS,
  parameter int ROWS = text_pkg::ROWS
) (
  input  logic            clk,
  input  logic            rst,
  text_writer_if.slave    bus
);

  import text_pkg::*;

  localparam logic [1:0] ST_INIT = INIT;
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CLR  = CLR_ROW;

  localparam logic [6:0] LAST_COL   = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW   = 5'(ROWS - 1);
  localparam logic [4:0] ROWS_5     = 5'(ROWS);
  localparam logic [6:0] PROMPT_COL = 7'd2;

  logic [1:0] state_q, state_d;
  logic [6:0] col_q, col_d;      // INIT / CLR_ROW column walker
  logic [4:0] row_q, row_d;      // INIT row walker, or physical row being cleared
  logic       prompt_q, prompt_d;  // cleared row gets '>' in column 0
  logic [4:0] top_q, top_d;
  logic [6:0] cx_q, cx_d;
  logic [4:0] cy_q, cy_d;
  logic       wen_q, wen_d;
  logic [6:0] wh_q, wh_d;
  logic [4:0] wv_q, wv_d;
  logic [7:0] wd_q, wd_d;

  logic       accept;
  logic       do_nl;
  logic       nl_prompt;

  assign accept = bus.in_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    prompt_d  = prompt_q;
    top_d     = top_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    wen_d     = 1'b0;
    wh_d      = wh_q;
    wv_d      = wv_q;
    wd_d      = wd_q;
    do_nl     = 1'b0;
    nl_prompt = 1'b0;

    case (state_q)
      ST_INIT: begin
        wen_d = 1'b1;
        wh_d  = col_q;
        wv_d  = row_q;
        wd_d  = (col_q == 7'd0 && row_q == 5'd0) ? ASCII_PROMPT : ASCII_BLANK;
        if (col_q == LAST_COL) begin
          col_d = 7'd0;
          if (row_q == LAST_ROW) begin
            row_d   = 5'd0;
            state_d = ST_IDLE;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          col_d = col_q + 7'd1;
        end
      end

      ST_CLR: begin
        wen_d = 1'b1;
        wh_d  = col_q;
        wv_d  = row_q;
        wd_d  = (col_q == 7'd0 && prompt_q) ? ASCII_PROMPT : ASCII_BLANK;
        if (col_q == LAST_COL) begin
          col_d   = 7'd0;
          state_d = ST_IDLE;
        end else begin
          col_d = col_q + 7'd1;
        end
      end

      ST_IDLE: begin
        if (accept) begin
          if (is_printable(bus.in_ascii)) begin
            wen_d = 1'b1;
            wh_d  = cx_q;
            wv_d  = phys_row(top_q, cy_q, ROWS_5);
            wd_d  = bus.in_ascii;
            if (cx_q < LAST_COL) begin
              cx_d = cx_q + 7'd1;
            end else begin
              cx_d  = 7'd0;
              do_nl = 1'b1;
            end
          end else if (bus.in_ascii == ASCII_CR) begin
            cx_d      = PROMPT_COL;
            do_nl     = 1'b1;
            nl_prompt = 1'b1;
          end else if (bus.in_ascii == ASCII_BS) begin
            if (cx_q != 7'd0) begin
              wen_d = 1'b1;
              wh_d  = cx_q - 7'd1;
              wv_d  = phys_row(top_q, cy_q, ROWS_5);
              wd_d  = ASCII_BLANK;
              cx_d  = cx_q - 7'd1;
            end else if (cy_q != 5'd0) begin
              wen_d = 1'b1;
              wh_d  = LAST_COL;
              wv_d  = phys_row(top_q, cy_q - 5'd1, ROWS_5);
              wd_d  = ASCII_BLANK;
              cx_d  = LAST_COL;
              cy_d  = cy_q - 5'd1;
            end
          end

          if (do_nl) begin
            if (cy_q < LAST_ROW) begin
              // Rows below the cursor are always blank, so only the prompt
              // (if any) needs writing, and it shares this edge's write slot.
              cy_d = cy_q + 5'd1;
              if (nl_prompt) begin
                wen_d = 1'b1;
                wh_d  = 7'd0;
                wv_d  = phys_row(top_q, cy_q + 5'd1, ROWS_5);
                wd_d  = ASCII_PROMPT;
              end
            end else begin
              // Scroll: the old top row becomes the new bottom line and is
              // wiped column by column in CLR_ROW.
              top_d    = (top_q == LAST_ROW) ? 5'd0 : top_q + 5'd1;
              state_d  = ST_CLR;
              col_d    = 7'd0;
              row_d    = top_q;
              prompt_d = nl_prompt;
            end
          end
        end
      end

      default: begin
        state_d = ST_INIT;
        col_d   = 7'd0;
        row_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      col_q    <= 7'd0;
      row_q    <= 5'd0;
      prompt_q <= 1'b0;
      top_q    <= 5'd0;
      cx_q     <= PROMPT_COL;
      cy_q     <= 5'd0;
      wen_q    <= 1'b0;
      wh_q     <= 7'd0;
      wv_q     <= 5'd0;
      wd_q     <= 8'd0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      prompt_q <= prompt_d;
      top_q    <= top_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      wen_q    <= wen_d;
      wh_q     <= wh_d;
      wv_q     <= wv_d;
      wd_q     <= wd_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.vwren     = wen_q;
  assign bus.vwraddr_h = wh_q;
  assign bus.vwraddr_v = wv_q;
  assign bus.vwrdata   = wd_q;
  assign bus.top_row   = top_q;
  assign bus.cur_x     = cx_q;
  assign bus.cur_y     = cy_q;

endmodule

// File: tb/tb_text_writer.sv
// tb/tb_text_writer.sv - self-checking bench for text_writer
module tb_text_writer;

  logic clk;
  logic rst;

  text_writer_if tw_if();

  text_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (tw_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       wen;
    logic [6:0] h;
    logic [4:0] v;
    logic [7:0] d;
    logic [6:0] x;
    logic [4:0] y;
  } vec_t;

  vec_t vecs [13];

  int n_cmp  = 0;
  int n_fail = 0;
  int wr_count = 0;
  logic [7:0] vram [0:29][0:69];

  always @(negedge clk) begin
    if (tw_if.vwren === 1'b1) begin
      if (tw_if.vwraddr_v < 5'd30 && tw_if.vwraddr_h < 7'd70)
        vram[tw_if.vwraddr_v][tw_if.vwraddr_h] = tw_if.vwrdata;
      wr_count++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    int w;
    w = 0;
    while (tw_if.in_ready !== 1'b1 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) chk("ready_wait", tw_if.in_ready, 1);
    tw_if.in_valid = 1'b1;
    tw_if.in_ascii = c;
    @(posedge clk); #1;
    tw_if.in_valid = 1'b0;
  endtask

  task automatic run_init();
    int cyc;
    int bad;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 70; c++)
        vram[r][c] = 8'hFF;
    rst = 1'b1;
    tw_if.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    wr_count = 0;
    rst = 1'b0;
    cyc = 0;
    while (tw_if.in_ready !== 1'b1 && cyc < 2300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("init_ready_edge", cyc, 2100);
    @(negedge clk); #1;
    chk("init_write_count", wr_count, 2100);
    chk("init_cell00", vram[0][0], 8'h3E);
    bad = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 70; c++)
        if ((r != 0 || c != 0) && vram[r][c] !== 8'h00) bad++;
    chk("init_blank_cells", bad, 0);
    chk("init_cur_x", tw_if.cur_x, 2);
    chk("init_cur_y", tw_if.cur_y, 0);
    chk("init_top_row", tw_if.top_row, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int bad;
    int rdy_at;

    vecs[0]  = '{8'h41, 1'b1, 7'd2,  5'd0, 8'h41, 7'd3,  5'd0};
    vecs[1]  = '{8'h08, 1'b1, 7'd2,  5'd0, 8'h00, 7'd2,  5'd0};
    vecs[2]  = '{8'h7E, 1'b1, 7'd2,  5'd0, 8'h7E, 7'd3,  5'd0};
    vecs[3]  = '{8'h20, 1'b1, 7'd3,  5'd0, 8'h20, 7'd4,  5'd0};
    vecs[4]  = '{8'h1B, 1'b0, 7'd0,  5'd0, 8'h00, 7'd4,  5'd0};
    vecs[5]  = '{8'h7F, 1'b0, 7'd0,  5'd0, 8'h00, 7'd4,  5'd0};
    vecs[6]  = '{8'h0D, 1'b1, 7'd0,  5'd1, 8'h3E, 7'd2,  5'd1};
    vecs[7]  = '{8'h08, 1'b1, 7'd1,  5'd1, 8'h00, 7'd1,  5'd1};
    vecs[8]  = '{8'h08, 1'b1, 7'd0,  5'd1, 8'h00, 7'd0,  5'd1};
    vecs[9]  = '{8'h08, 1'b1, 7'd69, 5'd0, 8'h00, 7'd69, 5'd0};
    vecs[10] = '{8'h5A, 1'b1, 7'd69, 5'd0, 8'h5A, 7'd0,  5'd1};
    vecs[11] = '{8'h08, 1'b1, 7'd69, 5'd0, 8'h00, 7'd69, 5'd0};
    vecs[12] = '{8'h08, 1'b1, 7'd68, 5'd0, 8'h00, 7'd68, 5'd0};

    rst = 1'b1;
    tw_if.in_valid = 1'b0;
    tw_if.in_ascii = 8'h00;
    @(posedge clk); #1;
    chk("rst_vwren", tw_if.vwren, 0);
    chk("rst_in_ready", tw_if.in_ready, 0);
    chk("rst_vwraddr_h", tw_if.vwraddr_h, 0);
    chk("rst_vwraddr_v", tw_if.vwraddr_v, 0);
    chk("rst_vwrdata", tw_if.vwrdata, 0);

    run_init();

    for (int i = 0; i < 13; i++) begin
      send(vecs[i].code);
      chk($sformatf("vec%0d_vwren", i), tw_if.vwren, vecs[i].wen);
      if (vecs[i].wen) begin
        chk($sformatf("vec%0d_h", i), tw_if.vwraddr_h, vecs[i].h);
        chk($sformatf("vec%0d_v", i), tw_if.vwraddr_v, vecs[i].v);
        chk($sformatf("vec%0d_data", i), tw_if.vwrdata, vecs[i].d);
      end
      chk($sformatf("vec%0d_cur_x", i), tw_if.cur_x, vecs[i].x);
      chk($sformatf("vec%0d_cur_y", i), tw_if.cur_y, vecs[i].y);
      chk($sformatf("vec%0d_top", i), tw_if.top_row, 0);
      chk($sformatf("vec%0d_ready", i), tw_if.in_ready, 1);
    end

    // Back-to-back 'A','B' with in_valid held high
    send(8'h0D);
    tw_if.in_valid = 1'b1;
    tw_if.in_ascii = 8'h41;
    @(posedge clk); #1;
    chk("b2b_a_vwren", tw_if.vwren, 1);
    chk("b2b_a_h", tw_if.vwraddr_h, 2);
    chk("b2b_a_v", tw_if.vwraddr_v, 1);
    chk("b2b_a_data", tw_if.vwrdata, 8'h41);
    chk("b2b_a_ready", tw_if.in_ready, 1);
    tw_if.in_ascii = 8'h42;
    @(posedge clk); #1;
    tw_if.in_valid = 1'b0;
    chk("b2b_b_vwren", tw_if.vwren, 1);
    chk("b2b_b_h", tw_if.vwraddr_h, 3);
    chk("b2b_b_data", tw_if.vwrdata, 8'h42);
    chk("b2b_cur_x", tw_if.cur_x, 4);
    chk("b2b_ready", tw_if.in_ready, 1);

    // Backspace from column 0 of row 5 wraps to the end of row 4
    for (int i = 0; i < 4; i++) send(8'h0D);
    send(8'h08);
    send(8'h08);
    chk("bs05_pre_x", tw_if.cur_x, 0);
    chk("bs05_pre_y", tw_if.cur_y, 5);
    send(8'h08);
    chk("bs05_vwren", tw_if.vwren, 1);
    chk("bs05_h", tw_if.vwraddr_h, 69);
    chk("bs05_v", tw_if.vwraddr_v, 4);
    chk("bs05_data", tw_if.vwrdata, 0);
    chk("bs05_cur_x", tw_if.cur_x, 69);
    chk("bs05_cur_y", tw_if.cur_y, 4);

    // Walk to the bottom line, then Enter scrolls
    for (int i = 0; i < 25; i++) send(8'h0D);
    chk("bottom_cur_y", tw_if.cur_y, 29);
    chk("bottom_top", tw_if.top_row, 0);
    send(8'h0D);
    chk("scroll_top", tw_if.top_row, 1);
    chk("scroll_cur_x", tw_if.cur_x, 2);
    chk("scroll_cur_y", tw_if.cur_y, 29);
    chk("scroll_ready_low", tw_if.in_ready, 0);
    chk("scroll_no_edge_write", tw_if.vwren, 0);
    cnt = 0;
    bad = 0;
    rdy_at = -1;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk); #1;
      if (tw_if.vwren === 1'b1) begin
        if (tw_if.vwraddr_v !== 5'd0 || tw_if.vwraddr_h !== 7'(cnt) ||
            tw_if.vwrdata !== ((cnt == 0) ? 8'h3E : 8'h00)) bad++;
        cnt++;
      end
      if (tw_if.in_ready === 1'b1) begin
        rdy_at = j;
        break;
      end
    end
    chk("clr_ready_cycles", rdy_at, 70);
    chk("clr_write_count", cnt, 70);
    chk("clr_bad_cells", bad, 0);

    // Reset in the middle of a row clear
    send(8'h0D);
    chk("scroll2_top", tw_if.top_row, 2);
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
    end
    chk("midclr_vwren_before", tw_if.vwren, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midclr_vwren", tw_if.vwren, 0);
    chk("midclr_top", tw_if.top_row, 0);
    chk("midclr_cur_x", tw_if.cur_x, 2);
    chk("midclr_cur_y", tw_if.cur_y, 0);
    chk("midclr_ready", tw_if.in_ready, 0);
    run_init();

    // Backspace at (0,0) does nothing
    send(8'h08);
    send(8'h08);
    send(8'h08);
    chk("bs00_vwren", tw_if.vwren, 0);
    chk("bs00_cur_x", tw_if.cur_x, 0);
    chk("bs00_cur_y", tw_if.cur_y, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
